// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined ARM datapath: condition codes,
// the NZCV flags layout and the datapath / register-index widths.
package cpu_pkg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/cond_eval.sv
// A64 B.cond evaluator: decides whether a condition code is satisfied by the
// committed NZCV flags. Purely combinational.
module cond_eval
  import cpu_pkg::*;
(
  input  nzcv_t flags,
  input  cond_e cond,
  output logic  cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      EQ: cond_true = flags.z;
      NE: cond_true = !flags.z;
      CS: cond_true = flags.c;
      CC: cond_true = !flags.c;
      MI: cond_true = flags.n;
      PL: cond_true = !flags.n;
      VS: cond_true = flags.v;
      VC: cond_true = !flags.v;
      HI: cond_true = flags.c && !flags.z;
      LS: cond_true = !(flags.c && !flags.z);
      GE: cond_true = (flags.n == flags.v);
      LT: cond_true = (flags.n != flags.v);
      GT: cond_true = !flags.z && (flags.n == flags.v);
      LE: cond_true = !(!flags.z && (flags.n == flags.v));
      AL: cond_true = 1'b1;
      NV: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register plus the architectural NZCV flags register.
// Optional macro COND_EVAL_EN instantiates the B.cond evaluator; without it cond_true is 0.
module ex_mem_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_negative,
  input  logic              ex_zero,
  input  logic              ex_overflow,
  input  logic              ex_carry_out,
  input  logic              ex_set_flags,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [3:0]        ex_cond,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic [3:0]        flags_nzcv,
  output logic              cond_true
);
  import cpu_pkg::*;

  logic  load;
  logic  flags_we;
  logic  keep;
  nzcv_t flags_q;

  assign load     = !stall || flush;
  assign flags_we = ex_valid && ex_set_flags && !stall && !flush;
  // control bits only survive for a real, unsquashed instruction
  assign keep     = ex_valid && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
    end else if (load) begin
      mem_valid      <= keep;
      mem_reg_write  <= keep && ex_reg_write;
      mem_mem_read   <= keep && ex_mem_read;
      mem_mem_write  <= keep && ex_mem_write;
      mem_result     <= ex_result;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else if (flags_we) begin
      flags_q <= '{n: ex_negative, z: ex_zero, c: ex_carry_out, v: ex_overflow};
    end
  end

  assign flags_nzcv = flags_q;

`ifdef COND_EVAL_EN
  cond_eval u_cond_eval (
    .flags    (flags_q),
    .cond     (cond_e'(ex_cond)),
    .cond_true(cond_true)
  );
`else
  logic unused_cond;
  assign unused_cond = ^ex_cond;
  assign cond_true   = 1'b0;
`endif

endmodule
